game_state_ctrl: RTL and testbench
==================================

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameter RESPAWN_CYCLES, default 25_000_000: cycles spent frozen after a hit (1 s at 25 MHz); legal range 1..2^27-1.
REQ-002 Parameter INVINC_CYCLES, default 50_000_000: cycles of invincible play after respawn; legal range 1..2^27-1.
REQ-003 Parameter OVER_CYCLES, default 75_000_000: cycles the game-over screen is held; legal range 1..2^27-1.
REQ-004 Port i_Clk, input, 1: the single clock.
REQ-005 Port i_Reset_n, input, 1: synchronous, active-low reset.
REQ-006 Port i_Start, input, 1: start button, level, already debounced.
REQ-007 Port i_Collision, input, 1: collision indicator, level.
REQ-008 Port i_Lives, input, 3: lives remaining, from the lives counter.
REQ-009 Port o_State, output, 3: current state encoding.
REQ-010 Port o_Lives_Reset, output, 1: one-cycle pulse that reloads the lives counter.
REQ-011 Port o_Hit, output, 1: one-cycle pulse that decrements the lives counter.
REQ-012 Port o_Freeze, output, 1: player movement frozen.
REQ-013 Port o_Invincible, output, 1: collisions are ignored.
REQ-014 Port o_Game_Over, output, 1: game-over display enable.

Function
REQ-015 State machine states: IDLE=0, PLAY=1, RESPAWN=2, INVINC=3, OVER=4. Codes 5-7 go to IDLE on the next cycle.
REQ-016 Edge definitions:
- start_edge = i_Start & ~start_d.
- coll_edge = i_Collision & ~coll_d.
- start_d and coll_d are registered every cycle in every state.
REQ-017 IDLE: on start_edge go to PLAY; o_Lives_Reset is high for exactly the first cycle of PLAY.
REQ-018 PLAY, on coll_edge with i_Lives >= 2:
- go to RESPAWN;
- o_Hit is high for exactly the first cycle of RESPAWN;
- the timer loads RESPAWN_CYCLES-1.
REQ-019 PLAY, on coll_edge with i_Lives <= 1:
- go to OVER;
- o_Hit is high for the first cycle of OVER;
- the timer loads OVER_CYCLES-1.
REQ-020 PLAY with i_Lives == 0 and no edge: go to OVER (recovery path); o_Hit is not pulsed.
REQ-021 RESPAWN:
- o_Freeze=1 and o_Invincible=1;
- the timer decrements each cycle;
- at timer==0, go to INVINC and load INVINC_CYCLES-1;
- dwell is exactly RESPAWN_CYCLES cycles.
REQ-022 INVINC:
- o_Invincible=1;
- at timer==0, go to PLAY;
- dwell is exactly INVINC_CYCLES cycles.
REQ-023 OVER:
- o_Game_Over=1;
- at timer==0, go to IDLE;
- dwell is exactly OVER_CYCLES cycles;
- i_Start is ignored.
REQ-024 coll_edge outside PLAY is discarded. A collision held high across INVINC->PLAY does not trigger a hit; a new rising edge is required.
REQ-025 start_edge outside IDLE is ignored. Simultaneous start_edge and coll_edge in IDLE: go to PLAY only.
REQ-026 All outputs are registered.
- o_State equals the current state.
- Flags are a function of the current state only.
- o_Hit and o_Lives_Reset are never high in the same cycle.
REQ-027 The timer is 27 bits unsigned and never wraps; it only decrements while nonzero.

Reset
REQ-028 While i_Reset_n=0 at a clock edge:
- state=IDLE and timer=0;
- coll_d=0;
- start_d=1, so a start button held through reset does not start a game;
- all outputs=0, with o_State=0.
REQ-029 Reset mid-operation (any state, any timer value) takes effect on that edge with no o_Hit and no o_Lives_Reset pulse.

Structure
REQ-030 A shared package holds:
- the state encodings;
- the timer width (27);
- the default cycle constants;
- the initial lives value (3), which the lives counter also uses.
REQ-031 One sub-module: game_timer, a loadable 27-bit down-counter with load, value and zero flag. All state logic stays in game_state_ctrl.

Verification
Directed scenarios use RESPAWN=4, INVINC=6, OVER=8.
REQ-032 Start and play entry:
- stimulus: release reset with i_Start=1 held for 5 cycles, then drop it and raise it again;
- response: IDLE is held until the new edge; then PLAY with one o_Lives_Reset pulse.
REQ-033 Single hit:
- stimulus: in PLAY, i_Lives=3, i_Collision pulse;
- response: one o_Hit cycle; RESPAWN for exactly 4 cycles with o_Freeze=1; INVINC for exactly 6 cycles; then PLAY.
REQ-034 Collisions during protection and held collision:
- stimulus: i_Collision toggled during RESPAWN and INVINC, then held high into PLAY;
- response: no o_Hit and no state change; no hit in PLAY until i_Collision falls and rises again.
REQ-035 Last life:
- stimulus: in PLAY, i_Lives=1, collision edge;
- response: o_Hit once; OVER with o_Game_Over=1 for exactly 8 cycles, with i_Start pulses ignored; then IDLE.
REQ-036 Reset mid-RESPAWN:
- stimulus: i_Reset_n low for 1 cycle at timer=2;
- response: next cycle state=IDLE, all outputs 0, no pulses.
REQ-037 Zero-lives recovery:
- stimulus: in PLAY, i_Lives=0, no collision;
- response: OVER on the next cycle with no o_Hit.

Source files
------------

// File: rtl/game_state_ctrl_pkg.sv
// game_state_ctrl_pkg: state codes, timer width and default timing shared by the game control blocks
package game_state_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_RESPAWN = 3'd2,
    ST_INVINC  = 3'd3,
    ST_OVER    = 3'd4
  } state_t;
  localparam int TIMER_W = 27;
  localparam int DEF_RESPAWN_CYCLES = 25_000_000;
  localparam int DEF_INVINC_CYCLES = 50_000_000;
  localparam int DEF_OVER_CYCLES = 75_000_000;
  localparam logic [2:0] INIT_LIVES = 3'd3;
endpackage

// File: rtl/game_state_ctrl_timer.sv
// game_timer: loadable down-counter that holds at zero instead of wrapping
module game_timer
  import game_state_ctrl_pkg::*;
(
  input  logic               i_Clk,
  input  logic               i_Reset_n,
  input  logic               i_Load,
  input  logic [TIMER_W-1:0] i_Value,
  output logic               o_Zero
);
  logic [TIMER_W-1:0] r_count;
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) r_count <= '0;
    else if (i_Load) r_count <= i_Value;
    else if (r_count != '0) r_count <= r_count - 1'b1;
  end
  assign o_Zero = (r_count == '0);
endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: game flow FSM (idle, play, respawn, invincible, game over) with registered outputs
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int RESPAWN_CYCLES = DEF_RESPAWN_CYCLES,
  parameter int INVINC_CYCLES = DEF_INVINC_CYCLES,
  parameter int OVER_CYCLES = DEF_OVER_CYCLES
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_Start,
  input  logic       i_Collision,
  input  logic [2:0] i_Lives,
  output logic [2:0] o_State,
  output logic       o_Lives_Reset,
  output logic       o_Hit,
  output logic       o_Freeze,
  output logic       o_Invincible,
  output logic       o_Game_Over
);
  localparam logic [TIMER_W-1:0] RESPAWN_LOAD = TIMER_W'(RESPAWN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] INVINC_LOAD = TIMER_W'(INVINC_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OVER_LOAD = TIMER_W'(OVER_CYCLES - 1);
  state_t r_state;
  state_t w_next;
  logic r_start_d, r_coll_d;
  logic r_hit, r_lives_reset, r_freeze, r_invincible, r_game_over;
  logic w_start_edge, w_coll_edge, w_hit, w_lives_reset, w_zero, w_load;
  logic [TIMER_W-1:0] w_load_val;
  assign w_start_edge = i_Start & ~r_start_d;
  assign w_coll_edge = i_Collision & ~r_coll_d;
  always_comb begin
    w_next = r_state;
    w_hit = 1'b0;
    w_lives_reset = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start_edge) begin
        w_next = ST_PLAY;
        w_lives_reset = 1'b1;
      end
      ST_PLAY: if (w_coll_edge) begin
        w_next = (i_Lives >= 3'd2) ? ST_RESPAWN : ST_OVER;
        w_hit = 1'b1;
      end else if (i_Lives == 3'd0) w_next = ST_OVER;
      ST_RESPAWN: w_next = w_zero ? ST_INVINC : ST_RESPAWN;
      ST_INVINC: w_next = w_zero ? ST_PLAY : ST_INVINC;
      ST_OVER: w_next = w_zero ? ST_IDLE : ST_OVER;
      default: w_next = ST_IDLE;
    endcase
  end
  // the timer is armed only on entry to a timed state
  assign w_load = (w_next != r_state) && (w_next inside {ST_RESPAWN, ST_INVINC, ST_OVER});
  assign w_load_val = (w_next == ST_RESPAWN) ? RESPAWN_LOAD :
                      (w_next == ST_INVINC) ? INVINC_LOAD : OVER_LOAD;
  game_timer u_timer (
    .i_Clk(i_Clk),
    .i_Reset_n(i_Reset_n),
    .i_Load(w_load),
    .i_Value(w_load_val),
    .o_Zero(w_zero)
  );
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      r_state <= ST_IDLE;
      r_start_d <= 1'b1;
      r_coll_d <= 1'b0;
      r_hit <= 1'b0;
      r_lives_reset <= 1'b0;
      r_freeze <= 1'b0;
      r_invincible <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start_d <= i_Start;
      r_coll_d <= i_Collision;
      r_hit <= w_hit;
      r_lives_reset <= w_lives_reset;
      r_freeze <= (w_next == ST_RESPAWN);
      r_invincible <= (w_next == ST_RESPAWN) || (w_next == ST_INVINC);
      r_game_over <= (w_next == ST_OVER);
    end
  end
  assign o_State = r_state;
  assign o_Hit = r_hit;
  assign o_Lives_Reset = r_lives_reset;
  assign o_Freeze = r_freeze;
  assign o_Invincible = r_invincible;
  assign o_Game_Over = r_game_over;
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed and random stimulus scored against a dwell-count reference model
module tb_game_state_ctrl;
  localparam int RESP = 4;
  localparam int INV = 6;
  localparam int OVR = 8;
  logic i_Clk = 1'b0;
  logic i_Reset_n = 1'b0;
  logic i_Start = 1'b1;
  logic i_Collision = 1'b0;
  logic [2:0] i_Lives = 3'd3;
  logic [2:0] o_State;
  logic o_Lives_Reset, o_Hit, o_Freeze, o_Invincible, o_Game_Over;
  game_state_ctrl #(
    .RESPAWN_CYCLES(RESP),
    .INVINC_CYCLES(INV),
    .OVER_CYCLES(OVR)
  ) dut (
    .i_Clk(i_Clk),
    .i_Reset_n(i_Reset_n),
    .i_Start(i_Start),
    .i_Collision(i_Collision),
    .i_Lives(i_Lives),
    .o_State(o_State),
    .o_Lives_Reset(o_Lives_Reset),
    .o_Hit(o_Hit),
    .o_Freeze(o_Freeze),
    .o_Invincible(o_Invincible),
    .o_Game_Over(o_Game_Over)
  );
  always #5 i_Clk = ~i_Clk;
  logic [7:0] sb[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  // phase numbers are the visible game phases; m_el counts cycles already spent in the phase
  int m_ph = 0;
  int m_el = 0;
  logic m_ps = 1'b1;
  logic m_pc = 1'b0;
  task automatic step(input logic rst_n, input logic start, input logic coll, input logic [2:0] lives);
    logic se, ce, hit, lr;
    int nph;
    @(negedge i_Clk);
    i_Reset_n = rst_n;
    i_Start = start;
    i_Collision = coll;
    i_Lives = lives;
    hit = 1'b0;
    lr = 1'b0;
    if (!rst_n) begin
      m_ph = 0;
      m_el = 0;
      m_ps = 1'b1;
      m_pc = 1'b0;
    end else begin
      se = start && !m_ps;
      ce = coll && !m_pc;
      m_ps = start;
      m_pc = coll;
      nph = m_ph;
      if (m_ph == 0 && se) begin nph = 1; lr = 1'b1; end
      else if (m_ph == 1 && ce) begin hit = 1'b1; nph = (lives >= 2) ? 2 : 4; end
      else if (m_ph == 1 && lives == 0) nph = 4;
      else if (m_ph == 2 && m_el == RESP) nph = 3;
      else if (m_ph == 3 && m_el == INV) nph = 1;
      else if (m_ph == 4 && m_el == OVR) nph = 0;
      m_el = (nph != m_ph) ? 1 : m_el + 1;
      m_ph = nph;
    end
    sb.push_back({3'(m_ph), lr && rst_n, hit && rst_n, rst_n && m_ph == 2,
                  rst_n && (m_ph == 2 || m_ph == 3), rst_n && m_ph == 4});
  endtask
  initial begin
    logic [7:0] exp, got;
    forever begin
      @(posedge i_Clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        got = {o_State, o_Lives_Reset, o_Hit, o_Freeze, o_Invincible, o_Game_Over};
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL outputs cyc=%0d got st=%0d lr/hit/frz/inv/ovr=%b exp st=%0d lr/hit/frz/inv/ovr=%b",
                      cyc, got[7:5], got[4:0], exp[7:5], exp[4:0]);
      end
    end
  end
  initial begin
    repeat (3) step(0, 1, 0, 3);
    repeat (5) step(1, 1, 0, 3);
    step(1, 0, 0, 3);
    step(1, 1, 0, 3);
    repeat (3) step(1, 0, 0, 3);
    step(1, 0, 1, 3);
    repeat (14) step(1, 0, 0, 3);
    step(1, 0, 1, 3);
    for (int i = 0; i < 9; i++) step(1, 0, i[0], 3);
    repeat (6) step(1, 0, 1, 3);
    step(1, 0, 0, 3);
    step(1, 0, 1, 3);
    repeat (12) step(1, 0, 0, 3);
    step(1, 0, 1, 1);
    for (int i = 0; i < 10; i++) step(1, i[0], 0, 1);
    repeat (2) step(1, 0, 0, 3);
    step(1, 1, 0, 3);
    step(1, 0, 1, 3);
    repeat (2) step(1, 0, 0, 3);
    step(0, 0, 0, 3);
    repeat (2) step(1, 0, 0, 3);
    step(1, 1, 0, 3);
    step(1, 0, 0, 0);
    repeat (10) step(1, 0, 0, 3);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 149) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           ($urandom_range(0, 15) == 0) ? 3'd0 : 3'($urandom_range(1, 3)));
    repeat (3) @(posedge i_Clk);
    #2;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain left=%0d required=0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
